// File: rtl/accel_gen_if.sv
// Accelerometer stimulus bus: sample-source select in, serial line, last sample and frame strobe out.
// The generator side (master) drives the outputs; the consuming side (slave) drives mode.
interface accel_gen_if;
    logic [1:0]  mode;
    logic        TX_A;
    logic [13:0] tx_data;
    logic        frm_done;

    modport master (input mode, output TX_A, output tx_data, output frm_done);
    modport slave  (output mode, input TX_A, input tx_data, input frm_done);
endinterface

// File: rtl/accel_gen.sv
// Accelerometer sample generator: 14-bit samples sent as two UART bytes on TX_A (ACCEL_GEN_PARITY_EN adds even parity).
// Latency: first start bit GAP_CYCLES+1 clocks after reset; frame period 20*BAUD_DIV (22 with parity) + GAP_CYCLES + 1.
// Backpressure: none, free-running; mode is sampled only in LOAD.
module accel_gen #(
    parameter int          BAUD_DIV   = 16,
    parameter int          GAP_CYCLES = 256,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    accel_gen_if.master  bus
);

`ifdef ACCEL_GEN_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    localparam int CW = $clog2(((GAP_CYCLES > BAUD_DIV) ? GAP_CYCLES : BAUD_DIV) + 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(NBITS - 1);

    typedef enum logic [1:0] {S_GAP, S_LOAD, S_SEND_HI, S_SEND_LO} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]    r_bit, w_bit_nxt;
    logic          r_tx, w_tx_nxt;
    logic [13:0]   r_tx_data, w_data_nxt;
    logic          r_frm_done, w_done;
    logic [15:0]   r_lfsr, w_lfsr_step;
    logic [2:0]    r_idx;
    logic [13:0]   r_ramp, w_corner;
    logic          w_load;

    // Bit k of a byte on the wire: start, 8 data LSB first, optional even parity, stop.
    function automatic logic f_bit(input logic [7:0] b, input logic [3:0] k);
        logic [3:0] km1;
        km1 = k - 4'd1;
        if (k == 4'd0)
            return 1'b0;
        else if (k <= 4'd8)
            return b[km1[2:0]];
`ifdef ACCEL_GEN_PARITY_EN
        else if (k == 4'd9)
            return ^b;
`endif
        else
            return 1'b1;
    endfunction

    assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    always_comb begin
        w_corner = 14'h0000;
        case (r_idx)
            3'd0:    w_corner = 14'h1FFF;
            3'd1:    w_corner = 14'h2000;
            3'd2:    w_corner = 14'h0000;
            3'd3:    w_corner = 14'h3FFF;
            default: w_corner = 14'h0001;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_SEND_HI;
                w_cnt_nxt   = '0;
                w_bit_nxt   = 4'd0;
            end
            S_SEND_HI, S_SEND_LO: begin
                if (r_cnt == BAUD_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_bit == BIT_LAST) begin
                        w_bit_nxt = 4'd0;
                        if (r_state == S_SEND_HI) begin
                            w_state_nxt = S_SEND_LO;
                        end else begin
                            w_state_nxt = S_GAP;
                            w_done      = 1'b1;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = '0;
                w_bit_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_data_nxt = r_tx_data;
        if (w_load) begin
            case (bus.mode)
                2'd0:    w_data_nxt = 14'h0000;
                2'd1:    w_data_nxt = w_lfsr_step[13:0];
                2'd2:    w_data_nxt = w_corner;
                default: w_data_nxt = r_ramp + 14'd1;
            endcase
        end
    end

    // TX_A is registered from the next state so each bit lands exactly on its cycle boundary.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_SEND_HI: w_tx_nxt = f_bit({2'b00, w_data_nxt[13:8]}, w_bit_nxt);
            S_SEND_LO: w_tx_nxt = f_bit(w_data_nxt[7:0], w_bit_nxt);
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_GAP;
            r_cnt      <= '0;
            r_bit      <= 4'd0;
            r_tx       <= 1'b1;
            r_tx_data  <= 14'h0000;
            r_frm_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_data  <= w_data_nxt;
            r_frm_done <= w_done;
        end
    end

    // Only the generator selected at LOAD advances; the others hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
            r_idx  <= 3'd0;
            r_ramp <= 14'h0000;
        end else if (w_load) begin
            case (bus.mode)
                2'd1: r_lfsr <= w_lfsr_step;
                2'd2: r_idx  <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
                2'd3: r_ramp <= r_ramp + 14'd1;
                default: ;
            endcase
        end
    end

    assign bus.TX_A     = r_tx;
    assign bus.tx_data  = r_tx_data;
    assign bus.frm_done = r_frm_done;

endmodule

// File: tb/tb_accel_gen.sv
// Directed bench for accel_gen: decodes TX_A as a UART and checks timing, bytes and samples.
module tb_accel_gen;
    localparam int B = 4;
    localparam int G = 8;
`ifdef ACCEL_GEN_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int LIM = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   rel = 0;
    int   n_tot = 0;
    int   n_bad = 0;
    int   n_done = 0;

    accel_gen_if ag_if ();

    accel_gen #(.BAUD_DIV(B), .GAP_CYCLES(G), .LFSR_SEED(16'hACE1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ag_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        if (ag_if.frm_done) n_done++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_release();
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
    endtask

    task automatic wait_start(input string tag, output int t);
        logic found;
        found = 1'b0;
        t     = 0;
        for (int i = 0; i < LIM && !found; i++) begin
            @(posedge clk); #1;
            if (!ag_if.TX_A) begin
                found = 1'b1;
                t     = cyc;
            end
        end
        chk({tag, "_start_seen"}, found, 1'b1);
    endtask

    task automatic wait_done(input string tag, output int t);
        logic found;
        found = 1'b0;
        t     = 0;
        for (int i = 0; i < 4 * B && !found; i++) begin
            @(posedge clk); #1;
            if (ag_if.frm_done) begin
                found = 1'b1;
                t     = cyc;
            end
        end
        chk({tag, "_done_seen"}, found, 1'b1);
    endtask

    task automatic rx_byte(input string tag, output logic [7:0] d, output logic par, output int t0);
        d   = 8'h00;
        par = 1'b0;
        wait_start(tag, t0);
        repeat (B / 2) @(posedge clk);
        #1 chk({tag, "_startbit"}, ag_if.TX_A, 1'b0);
        for (int k = 0; k < 8; k++) begin
            repeat (B) @(posedge clk);
            #1 d[k] = ag_if.TX_A;
        end
`ifdef ACCEL_GEN_PARITY_EN
        repeat (B) @(posedge clk);
        #1 par = ag_if.TX_A;
`endif
        repeat (B) @(posedge clk);
        #1 chk({tag, "_stopbit"}, ag_if.TX_A, 1'b1);
    endtask

    task automatic rx_frame(input string tag, output logic [7:0] hi, output logic [7:0] lo,
                            output logic hp, output logic lp, output int t_hi);
        int t_lo, t_dn;
        rx_byte({tag, "_hi"}, hi, hp, t_hi);
        rx_byte({tag, "_lo"}, lo, lp, t_lo);
        chk({tag, "_lo_start"}, t_lo - t_hi, NB * B);
        wait_done(tag, t_dn);
        chk({tag, "_frm_len"}, t_dn - t_hi, 2 * NB * B);
    endtask

    logic [7:0]  hi, lo;
    logic        hp, lp;
    int          t0, t_prev, nd;
    logic [13:0] prev;
    logic [13:0] corner_exp [6] = '{14'h1FFF, 14'h2000, 14'h0000, 14'h3FFF, 14'h0001, 14'h1FFF};
    logic [13:0] rnd_exp    [3] = '{14'h19C3, 14'h3387, 14'h270F};

    initial begin
        ag_if.mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", ag_if.TX_A, 1'b1);
        chk("rst_data", ag_if.tx_data, 14'h0);
        chk("rst_done", ag_if.frm_done, 1'b0);

        // mode 0: first-frame latency, zero bytes, one-cycle done pulse
        do_release();
        rx_frame("zero", hi, lo, hp, lp, t0);
        chk("zero_first_start", t0 - rel, G + 1);
        chk("zero_hi", hi, 8'h00);
        chk("zero_lo", lo, 8'h00);
        chk("zero_data", ag_if.tx_data, 14'h0);
        @(posedge clk); #1;
        chk("zero_done_width", ag_if.frm_done, 1'b0);

        // mode 2: corner sequence with wrap
        rst_n = 1'b0;
        ag_if.mode = 2'd2;
        repeat (2) @(posedge clk);
        do_release();
        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            rx_frame($sformatf("corner%0d", i), hi, lo, hp, lp, t0);
            chk($sformatf("corner%0d_data", i), ag_if.tx_data, corner_exp[i]);
            chk($sformatf("corner%0d_hi", i), hi, {2'b00, corner_exp[i][13:8]});
            chk($sformatf("corner%0d_lo", i), lo, corner_exp[i][7:0]);
            if (i == 1) chk("corner_period", t0 - t_prev, 2 * NB * B + G + 1);
`ifdef ACCEL_GEN_PARITY_EN
            if (i == 0) begin
                chk("par_hi_1f", hp, 1'b1);
                chk("par_lo_ff", lp, 1'b0);
            end
`endif
            t_prev = t0;
        end

        // mode 1: LFSR from seed ACE1
        rst_n = 1'b0;
        ag_if.mode = 2'd1;
        repeat (2) @(posedge clk);
        do_release();
        prev = 14'h0;
        for (int i = 0; i < 3; i++) begin
            rx_frame($sformatf("rnd%0d", i), hi, lo, hp, lp, t0);
            chk($sformatf("rnd%0d_data", i), ag_if.tx_data, rnd_exp[i]);
            chk($sformatf("rnd%0d_lo", i), lo, rnd_exp[i][7:0]);
            if (i > 0) chk($sformatf("rnd%0d_differs", i), (ag_if.tx_data != prev), 1'b1);
            prev = ag_if.tx_data;
        end

        // mode 3: ramp, then a mid-frame switch to mode 0
        rst_n = 1'b0;
        ag_if.mode = 2'd3;
        repeat (2) @(posedge clk);
        do_release();
        for (int i = 1; i <= 2; i++) begin
            rx_frame($sformatf("ramp%0d", i), hi, lo, hp, lp, t0);
            chk($sformatf("ramp%0d_data", i), ag_if.tx_data, 14'(i));
        end
        rx_byte("ramp3_hi", hi, hp, t0);
        ag_if.mode = 2'd0;
        rx_byte("ramp3_lo", lo, lp, t_prev);
        wait_done("ramp3", nd);
        chk("ramp3_lo_byte", lo, 8'h03);
        chk("ramp3_data_held", ag_if.tx_data, 14'h0003);
        rx_frame("after_switch", hi, lo, hp, lp, t0);
        chk("after_switch_data", ag_if.tx_data, 14'h0000);
        chk("after_switch_lo", lo, 8'h00);

        // reset during bit 4 of the high byte aborts the frame
        rst_n = 1'b0;
        ag_if.mode = 2'd3;
        repeat (2) @(posedge clk);
        do_release();
        wait_start("abort", t0);
        chk("abort_first_start", t0 - rel, G + 1);
        repeat (4 * B + B / 2) @(posedge clk);
        #1;
        chk("abort_pre_tx", ag_if.TX_A, 1'b0);
        chk("abort_pre_data", ag_if.tx_data, 14'h0001);
        nd = n_done;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx_high", ag_if.TX_A, 1'b1);
        chk("abort_data_zero", ag_if.tx_data, 14'h0);
        chk("abort_done_low", ag_if.frm_done, 1'b0);
        repeat (2) @(posedge clk);
        do_release();
        wait_start("abort_restart", t0);
        chk("abort_restart_gap", t0 - rel, G + 1);
        chk("abort_no_done", n_done, nd);
        chk("abort_restart_data", ag_if.tx_data, 14'h0001);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
